stonyman_dac_controller: RTL and testbench
==========================================

Name: stonyman_dac_controller

Overview:
- SPI-style write master for a TI DACxx1S101-family DAC (DAC121S101 frame format) driving Stonyman bias/reference voltages.
- Pops 12-bit codes from an upstream FIFO, builds 16-bit frames and shifts them out MSB-first on SCLK/SYNC_n/DIN at clk/2.
- Transmit-side counterpart of the pixel ADC read path; sits on the same 40 MHz fabric clock.

Parameters:
- DATA_BITS, 12, DAC code width taken from the FIFO.
- FRAME_BITS, 16, bits per DAC frame.
- SYNC_HIGH_COUNTS, 4, clk cycles SYNC_n is held high after each frame; minimum 1.

Ports:
- clk  in  1  40 MHz fabric clock.
- reset  in  1  synchronous, active-high.
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_read_data  in  12  FIFO data, valid the cycle after fifo_read_enable.
- pd_mode  in  2  DAC power-down bits DB13:12; 00 = normal operation.
- fifo_read_enable  out  1  one-cycle FIFO pop, registered.
- frame_done  out  1  one-cycle pulse at end of each frame's SYNC-high gap.
- dac_busy  out  1  high in every state except IDLE.
- sclk  out  1  DAC serial clock; idles high.
- sync_n  out  1  DAC frame sync, active low.
- din  out  1  DAC serial data.
- dac_state  out  3  test point, current state encoding.

Behaviour:
- Reset values: fifo_read_enable=0, frame_done=0, dac_busy=0, sclk=1, sync_n=1, din=0, dac_state=IDLE. Shift register and counters cleared.
- All outputs are registered.
- States: IDLE=0, FETCH=1, LOAD=2, SHIFT=3, HOLD=4.
- IDLE: sclk=1, sync_n=1. If ~fifo_empty -> FETCH.
- FETCH: fifo_read_enable=1 for exactly this cycle -> LOAD.
- LOAD: capture the frame {2'b00, pd_mode, fifo_read_data} -> SHIFT. pd_mode is sampled here only.
- Entering SHIFT (the cycle after LOAD): sync_n=0, sclk=1, din=frame[15].
- SHIFT: sclk toggles every clk.
  - The DAC samples din on each sclk falling edge.
  - On each sclk rising edge inside the frame, din advances to the next lower bit.
- After the 16th falling edge, the next cycle sets sclk=1, sync_n=1, din=0 -> HOLD.
- sync_n is low for exactly 2*FRAME_BITS=32 clk cycles with exactly 16 sclk falling edges.
- HOLD: counts SYNC_HIGH_COUNTS cycles with sync_n=1, sclk=1. On exit, frame_done=1 for one cycle. Next state is FETCH if ~fifo_empty, else IDLE (back-to-back frames skip IDLE).
- Latency with SYNC_HIGH_COUNTS=4: fifo_empty low seen in IDLE at cycle 0 -> read_en cycle 1 -> sync_n falls cycle 3 -> sync_n rises cycle 35 -> frame_done cycle 39.
- Bit counter is 5 bits. SHIFT exits when the counter reaches FRAME_BITS with no wrap.
- fifo_empty is ignored outside IDLE and HOLD exit. This block is the only FIFO reader.
- Reset mid-frame: sync_n returns high on the next edge, which aborts the frame at the DAC. No frame_done. Any popped word is discarded.
- fifo_empty toggling during SHIFT or HOLD has no effect on the frame in flight.

Optional Feature:
- DAC_FRAME_COUNT_EN
  - Defined: adds output frames_sent[15:0]. It increments with each frame_done, wraps 16'hFFFF->0 and is cleared by reset.
  - Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encodings, STATE_BITS=3, FRAME_BITS, PD_NORMAL=2'b00 / PD_1K=2'b01 / PD_100K=2'b10 / PD_HIZ=2'b11, frame field offsets.
- One natural sub-module, dac_frame_shifter: a 16-bit parallel-load shift register with bit counter, driving din and a last_bit flag. The FSM stays in the top.

Test Plan:
- Single frame: FIFO holds 12'hA5C, pd_mode=00 -> one read_en pulse. DIN sampled at the 16 sclk falling edges = 16'h0A5C MSB-first. sync_n low 32 cycles. frame_done at cycle 39.
- Power-down bits: code 12'h000, pd_mode=11 -> captured frame 16'h3000.
- Back-to-back: three words queued -> three frames. Gap between sync_n rise and next fall = SYNC_HIGH_COUNTS+3 cycles (7). No IDLE visit between frames.
- Reset at 10th falling edge -> next cycle sync_n=1, sclk=1, state IDLE, no frame_done. A refilled FIFO then sends a full clean frame.
- Empty FIFO for 100 cycles -> read_en never asserted, sclk=1, sync_n=1, dac_busy=0.
- With DAC_FRAME_COUNT_EN: preload frames_sent to 16'hFFFE by forcing, send 3 frames -> count reads 16'h0001.

Source files
------------

// File: rtl/stonyman_dac_controller_pkg.sv
// Shared state encodings and frame layout for the Stonyman DAC write master
// (DAC121S101 frame: 2'b00, two power-down bits, 12-bit code).
package stonyman_dac_controller_pkg;

  localparam int STATE_BITS     = 3;
  localparam int DAC_FRAME_BITS = 16;
  localparam int DAC_DATA_BITS  = 12;

  typedef enum logic [STATE_BITS-1:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4
  } dac_state_t;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  localparam int FRAME_DATA_LSB = 0;
  localparam int FRAME_PD_LSB   = 12;
  localparam int FRAME_PD_MSB   = 13;

endpackage

// File: rtl/stonyman_dac_controller_dac_frame_shifter.sv
// Parallel-load MSB-first shift register for one DAC frame; din is the
// register MSB and last_bit flags that every bit has been sampled.
module dac_frame_shifter #(
  parameter int FRAME_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame_in,
  input  logic                  sample,
  input  logic                  advance,
  input  logic                  clear,
  output logic                  din,
  output logic                  last_bit
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] shift_next;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [CNT_W-1:0]      bit_cnt_next;

  assign shift_next[0] = clear ? 1'b0 :
                         load  ? frame_in[0] :
                         advance ? 1'b0 : shift_reg[0];

  genvar gi;
  generate
    for (gi = 1; gi < FRAME_BITS; gi++) begin : g_shift_bit
      assign shift_next[gi] = clear ? 1'b0 :
                              load  ? frame_in[gi] :
                              advance ? shift_reg[gi-1] : shift_reg[gi];
    end
  endgenerate

  // Counts sclk falling edges; stops at FRAME_BITS, never wraps.
  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    if (clear || load) begin
      bit_cnt_next = '0;
    end else if (sample) begin
      bit_cnt_next = bit_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  assign din      = shift_reg[FRAME_BITS-1];
  assign last_bit = (bit_cnt_reg == CNT_W'(FRAME_BITS));

endmodule

// File: rtl/stonyman_dac_controller.sv
// SPI-style DAC write master: pops 12-bit codes and shifts 16-bit frames out at clk/2.
// Optional DAC_FRAME_COUNT_EN adds a wrapping frames_sent counter output.
module stonyman_dac_controller
  import stonyman_dac_controller_pkg::*;
#(
  parameter int DATA_BITS        = DAC_DATA_BITS,
  parameter int FRAME_BITS       = DAC_FRAME_BITS,
  parameter int SYNC_HIGH_COUNTS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_BITS-1:0]  fifo_read_data,
  input  logic [1:0]            pd_mode,
  output logic                  fifo_read_enable,
  output logic                  frame_done,
  output logic                  dac_busy,
  output logic                  sclk,
  output logic                  sync_n,
  output logic                  din,
`ifdef DAC_FRAME_COUNT_EN
  output logic [15:0]           frames_sent,
`endif
  output logic [STATE_BITS-1:0] dac_state
);

  localparam int PAD_BITS = FRAME_BITS - DATA_BITS - 2;
  localparam int HOLD_W   = (SYNC_HIGH_COUNTS > 1) ? $clog2(SYNC_HIGH_COUNTS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SYNC_HIGH_COUNTS - 1);

  dac_state_t state_reg;
  dac_state_t state_next;

  logic              read_en_reg;
  logic              read_en_next;
  logic              frame_done_reg;
  logic              frame_done_next;
  logic              busy_reg;
  logic              busy_next;
  logic              sclk_reg;
  logic              sclk_next;
  logic              sync_n_reg;
  logic              sync_n_next;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_next;

  logic                  shift_load;
  logic                  shift_sample;
  logic                  shift_advance;
  logic                  shift_clear;
  logic                  last_bit;
  logic [FRAME_BITS-1:0] frame_word;

  assign frame_word = {{PAD_BITS{1'b0}}, pd_mode, fifo_read_data};

  dac_frame_shifter #(
    .FRAME_BITS(FRAME_BITS)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (shift_load),
    .frame_in (frame_word),
    .sample   (shift_sample),
    .advance  (shift_advance),
    .clear    (shift_clear),
    .din      (din),
    .last_bit (last_bit)
  );

  always_comb begin
    state_next      = state_reg;
    read_en_next    = 1'b0;
    frame_done_next = 1'b0;
    sclk_next       = sclk_reg;
    sync_n_next     = sync_n_reg;
    hold_cnt_next   = hold_cnt_reg;
    shift_load      = 1'b0;
    shift_sample    = 1'b0;
    shift_advance   = 1'b0;
    shift_clear     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        sclk_next   = 1'b1;
        sync_n_next = 1'b1;
        if (!fifo_empty) begin
          state_next   = ST_FETCH;
          read_en_next = 1'b1;
        end
      end
      ST_FETCH: begin
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        // FIFO data is valid this cycle; pd_mode is latched only here.
        shift_load  = 1'b1;
        sync_n_next = 1'b0;
        sclk_next   = 1'b1;
        state_next  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sclk_reg) begin
          sclk_next    = 1'b0;
          shift_sample = 1'b1;
        end else if (last_bit) begin
          sclk_next     = 1'b1;
          sync_n_next   = 1'b1;
          shift_clear   = 1'b1;
          hold_cnt_next = '0;
          state_next    = ST_HOLD;
        end else begin
          sclk_next     = 1'b1;
          shift_advance = 1'b1;
        end
      end
      ST_HOLD: begin
        sclk_next   = 1'b1;
        sync_n_next = 1'b1;
        // frame_done is raised on the last counted cycle and the exit
        // decision is taken while it is high.
        if (frame_done_reg) begin
          hold_cnt_next = '0;
          if (!fifo_empty) begin
            state_next   = ST_FETCH;
            read_en_next = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (hold_cnt_reg == HOLD_LAST) begin
          frame_done_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      default: begin
        sclk_next   = 1'b1;
        sync_n_next = 1'b1;
        state_next  = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      read_en_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
      sclk_reg       <= 1'b1;
      sync_n_reg     <= 1'b1;
      hold_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      read_en_reg    <= read_en_next;
      frame_done_reg <= frame_done_next;
      busy_reg       <= busy_next;
      sclk_reg       <= sclk_next;
      sync_n_reg     <= sync_n_next;
      hold_cnt_reg   <= hold_cnt_next;
    end
  end

`ifdef DAC_FRAME_COUNT_EN
  logic [15:0] frames_sent_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_sent_reg <= '0;
    end else if (frame_done_next) begin
      frames_sent_reg <= frames_sent_reg + 16'd1;
    end
  end

  assign frames_sent = frames_sent_reg;
`endif

  assign fifo_read_enable = read_en_reg;
  assign frame_done       = frame_done_reg;
  assign dac_busy         = busy_reg;
  assign sclk             = sclk_reg;
  assign sync_n           = sync_n_reg;
  assign dac_state        = state_reg;

endmodule

// File: tb/tb_stonyman_dac_controller.sv
// Self-checking bench for stonyman_dac_controller: FIFO model, DAC-side frame
// decoder, table vectors, hand-written corner sequences and random bursts.
module tb_stonyman_dac_controller;

  localparam int SHC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty;
  logic [11:0] fifo_read_data;
  logic [1:0]  pd_mode;
  logic        fifo_read_enable;
  logic        frame_done;
  logic        dac_busy;
  logic        sclk;
  logic        sync_n;
  logic        din;
  logic [2:0]  dac_state;
`ifdef DAC_FRAME_COUNT_EN
  logic [15:0] frames_sent;
`endif

  stonyman_dac_controller #(
    .SYNC_HIGH_COUNTS(SHC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_empty       (fifo_empty),
    .fifo_read_data   (fifo_read_data),
    .pd_mode          (pd_mode),
    .fifo_read_enable (fifo_read_enable),
    .frame_done       (frame_done),
    .dac_busy         (dac_busy),
    .sclk             (sclk),
    .sync_n           (sync_n),
    .din              (din),
`ifdef DAC_FRAME_COUNT_EN
    .frames_sent      (frames_sent),
`endif
    .dac_state        (dac_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] code;
    logic [1:0]  pd;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_count = 0;
  int frame_no = 0;
  int idle_cycles = 0;
  int rise_cyc = 0;
  int last_done_cyc = 0;
  int nfall = 0;
  int nlow = 0;

  logic [11:0] fifo_q[$];
  logic [15:0] exp_q[$];
  int          re_q[$];
  int          fall_q[$];
  int          rise_q[$];

  logic [11:0] popped;
  logic [15:0] bits;
  logic [15:0] last_bits;
  logic [1:0]  burst_pd = 2'b00;
  logic        prev_sync_n = 1'b1;
  logic        prev_sclk = 1'b1;
  bit          pend = 0;
  bit          in_frame = 0;
  bit          frame_ok = 0;
  bit          abort_pending = 0;
  bit          scramble = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int qat(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1000;
  endfunction

  task automatic push(input logic [11:0] code, input logic [15:0] frame);
    fifo_q.push_back(code);
    exp_q.push_back(frame);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_history();
    re_q.delete();
    fall_q.delete();
    rise_q.delete();
  endtask

  // One clock: FIFO model update, then decode what the DAC pins did this cycle.
  task automatic tick();
    logic [15:0] exp;
    @(posedge clk);
    #1;
    cyc++;
    if (pend) begin
      fifo_read_data = popped;
      pend = 0;
    end else begin
      fifo_read_data = 12'($urandom);
    end
    if (fifo_read_enable === 1'b1) begin
      check("pop_while_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) begin
        popped = fifo_q.pop_front();
        pend = 1;
      end
      re_q.push_back(cyc);
    end
    fifo_empty = (fifo_q.size() == 0);

    if (sync_n === 1'b0) begin
      if (prev_sync_n !== 1'b0) begin
        in_frame = 1;
        bits = '0;
        nfall = 0;
        nlow = 0;
        fall_q.push_back(cyc);
      end
      nlow++;
      if (prev_sclk === 1'b1 && sclk === 1'b0) begin
        bits = {bits[14:0], din};
        nfall++;
      end
      check("busy_in_frame", dac_busy, 1);
      if (scramble) pd_mode = 2'($urandom);
    end else begin
      if (in_frame) begin
        in_frame = 0;
        rise_cyc = cyc;
        rise_q.push_back(cyc);
        pd_mode = burst_pd;
        if (abort_pending) begin
          abort_pending = 0;
          frame_ok = 0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          check("frame_expected", exp_q.size() != 0, 1);
          exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
          check("frame_bits", bits, exp);
          check("sync_low_cycles", nlow, 32);
          check("falling_edges", nfall, 16);
          $display("frame %0d: din=%04h expected=%04h low=%0d falls=%0d", frame_no, bits, exp, nlow, nfall);
          last_bits = bits;
          frame_no++;
          frame_ok = 1;
        end
      end
      if (sync_n === 1'b1) begin
        check("sclk_high_outside_frame", sclk, 1);
        check("din_low_outside_frame", din, 0);
      end
    end

    if (frame_done === 1'b1) begin
      done_count++;
      last_done_cyc = cyc;
      check("frame_done_gap", cyc - rise_cyc, SHC);
      check("frame_done_after_full_frame", frame_ok, 1);
      frame_ok = 0;
    end
    if (dac_state === 3'd0) idle_cycles++;
    prev_sync_n = sync_n;
    prev_sclk = sclk;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      tick();
      n++;
    end
    check("frames_completed", done_count, target);
  endtask

  initial begin
    int c0;
    int base;
    int idle0;
    int n;
    logic [11:0] code;

    vecs[0] = '{12'hA5C, 2'b00, 16'h0A5C};
    vecs[1] = '{12'h000, 2'b11, 16'h3000};
    vecs[2] = '{12'hFFF, 2'b01, 16'h1FFF};
    vecs[3] = '{12'h123, 2'b10, 16'h2123};
    vecs[4] = '{12'h800, 2'b00, 16'h0800};
    vecs[5] = '{12'h001, 2'b11, 16'h3001};

    reset = 1'b1;
    fifo_empty = 1'b1;
    fifo_read_data = '0;
    pd_mode = 2'b00;

    repeat (3) tick();
    check("reset_read_en", fifo_read_enable, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_busy", dac_busy, 0);
    check("reset_sclk", sclk, 1);
    check("reset_sync_n", sync_n, 1);
    check("reset_din", din, 0);
    check("reset_state", dac_state, 0);
`ifdef DAC_FRAME_COUNT_EN
    check("reset_frames_sent", frames_sent, 0);
`endif
    reset = 1'b0;
    tick();

    // Empty FIFO: nothing may move.
    for (int i = 0; i < 100; i++) begin
      tick();
      check("empty_read_en", fifo_read_enable, 0);
      check("empty_sclk", sclk, 1);
      check("empty_sync_n", sync_n, 1);
      check("empty_busy", dac_busy, 0);
    end

    // Single-frame latency from IDLE.
    clear_history();
    c0 = cyc;
    push(12'hA5C, 16'h0A5C);
    wait_frames(done_count + 1, 80);
    check("single_read_pulses", re_q.size(), 1);
    check("latency_read_en", qat(re_q, 0) - c0, 1);
    check("latency_sync_fall", qat(fall_q, 0) - c0, 3);
    check("latency_sync_rise", qat(rise_q, 0) - c0, 35);
    check("latency_frame_done", last_done_cyc - c0, 39);
    repeat (2) tick();
    check("idle_after_frame", dac_state, 0);
    check("not_busy_after_frame", dac_busy, 0);

    // Table vectors, one frame each.
    for (int i = 0; i < 6; i++) begin
      burst_pd = vecs[i].pd;
      pd_mode = vecs[i].pd;
      push(vecs[i].code, vecs[i].frame);
      wait_frames(done_count + 1, 80);
      check("table_frame", last_bits, vecs[i].frame);
      repeat (3) tick();
    end

    // Back-to-back: three queued words, no IDLE between frames.
    burst_pd = 2'b00;
    pd_mode = 2'b00;
    clear_history();
    idle0 = idle_cycles;
    push(12'h111, 16'h0111);
    push(12'h222, 16'h0222);
    push(12'h333, 16'h0333);
    wait_frames(done_count + 3, 200);
    check("b2b_read_pulses", re_q.size(), 3);
    check("b2b_gap_1", qat(fall_q, 1) - qat(rise_q, 0), SHC + 3);
    check("b2b_gap_2", qat(fall_q, 2) - qat(rise_q, 1), SHC + 3);
    check("b2b_no_idle", idle_cycles - idle0, 0);
    repeat (3) tick();

    // Reset at the 10th falling edge aborts the frame.
    code = 12'($urandom);
    push(code, {4'b0000, code});
    n = 0;
    while (!(in_frame && nfall == 10) && n < 60) begin
      tick();
      n++;
    end
    check("reached_tenth_fall", nfall, 10);
    abort_pending = 1;
    reset = 1'b1;
    tick();
    check("abort_sync_n", sync_n, 1);
    check("abort_sclk", sclk, 1);
    check("abort_state", dac_state, 0);
    check("abort_busy", dac_busy, 0);
    check("abort_frame_done", frame_done, 0);
    reset = 1'b0;
    base = done_count;
    repeat (50) tick();
    check("abort_no_frame_done", done_count, base);
    check("abort_no_pending_frames", exp_q.size(), 0);
    push(12'h5A3, 16'h05A3);
    wait_frames(done_count + 1, 80);
    check("post_abort_frame", last_bits, 16'h05A3);

    // Random bursts with words arriving mid-frame and pd_mode noise during frames.
    scramble = 1;
    for (int b = 0; b < 8; b++) begin
      burst_pd = 2'($urandom);
      pd_mode = burst_pd;
      base = done_count;
      n = $urandom_range(1, 4);
      for (int w = 0; w < n; w++) begin
        repeat ($urandom_range(0, 40)) tick();
        code = 12'($urandom);
        push(code, 16'(burst_pd) * 16'h1000 + 16'(code));
      end
      wait_frames(base + n, 60 * n + 60);
      repeat ($urandom_range(0, 5)) tick();
    end
    scramble = 0;
    pd_mode = 2'b00;
    burst_pd = 2'b00;

`ifdef DAC_FRAME_COUNT_EN
    repeat (3) tick();
    force dut.frames_sent_reg = 16'hFFFE;
    tick();
    release dut.frames_sent_reg;
    push(12'h00A, 16'h000A);
    push(12'h00B, 16'h000B);
    push(12'h00C, 16'h000C);
    wait_frames(done_count + 3, 200);
    tick();
    check("frames_sent_wrap", frames_sent, 16'h0001);
`endif

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
